// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, instruction classes, opcodes
// and the Capture-IR pattern (sliced to IR_WIDTH by the users).
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR     = 4'h0,
        RTI     = 4'h1,
        SelDR   = 4'h2,
        CapDR   = 4'h3,
        ShDR    = 4'h4,
        Ex1DR   = 4'h5,
        PauseDR = 4'h6,
        Ex2DR   = 4'h7,
        UpdDR   = 4'h8,
        SelIR   = 4'h9,
        CapIR   = 4'hA,
        ShIR    = 4'hB,
        Ex1IR   = 4'hC,
        PauseIR = 4'hD,
        Ex2IR   = 4'hE,
        UpdIR   = 4'hF
    } tapStateE;

    typedef enum logic [1:0] {
        InstrExtest,
        InstrSample,
        InstrIdcode,
        InstrBypass
    } instrE;

    localparam logic [7:0] opExtest     = 8'h00;
    localparam logic [7:0] opSample     = 8'h01;
    localparam logic [7:0] opIdcode     = 8'h02;
    localparam logic [7:0] capIrPattern = 8'h01;

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// TAP serial pins plus boundary-chain control bundle.
// master = tester/boundary-chain side, slave = TAP controller.
interface jtag_tap_ctrl_if;
    logic TMS;
    logic TDI;
    logic TDO;
    logic TDO_EN;
    logic ScanIn;
    logic ScanOut;
    logic ShiftDR;
    logic CaptureDR;
    logic UpdateDR;
    logic Mode;

    modport master (
        output TMS, TDI, ScanOut,
        input  TDO, TDO_EN, ScanIn, ShiftDR, CaptureDR, UpdateDR, Mode
    );

    modport slave (
        input  TMS, TDI, ScanOut,
        output TDO, TDO_EN, ScanIn, ShiftDR, CaptureDR, UpdateDR, Mode
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state register and next-state logic, advanced on posedge tck
// with a synchronous active-low reset to Test-Logic-Reset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic     tck,
    input  logic     trstN,
    input  logic     tms,
    output tapStateE state
);

    always_ff @(posedge tck) begin
        if (!trstN) begin
            state <= TLR;
        end else begin
            case (state)
                TLR:                 state <= tms ? TLR     : RTI;
                RTI, UpdDR, UpdIR:   state <= tms ? SelDR   : RTI;
                SelDR:               state <= tms ? SelIR   : CapDR;
                SelIR:               state <= tms ? TLR     : CapIR;
                CapDR, ShDR:         state <= tms ? Ex1DR   : ShDR;
                Ex1DR:               state <= tms ? UpdDR   : PauseDR;
                PauseDR:             state <= tms ? Ex2DR   : PauseDR;
                Ex2DR:               state <= tms ? UpdDR   : ShDR;
                CapIR, ShIR:         state <= tms ? Ex1IR   : ShIR;
                Ex1IR:               state <= tms ? UpdIR   : PauseIR;
                PauseIR:             state <= tms ? Ex2IR   : PauseIR;
                Ex2IR:               state <= tms ? UpdIR   : ShIR;
                default:             state <= TLR;
            endcase
        end
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, bypass, optional 32-bit ID register (JTAG_IDCODE_EN)
// and boundary-chain control decode. Posedge capture/shift, negedge TDO/IR latch.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h020F_30DD
) (
    input logic TCK,
    input logic TRST_N,
    jtag_tap_ctrl_if.slave tap
);

    if (IR_WIDTH < 2 || IR_WIDTH > 8) begin : gIrWidthCheck
        $error("jtag_tap_ctrl: IR_WIDTH must be within 2..8");
    end
    if (IDCODE_VALUE[0] != 1'b1) begin : gIdcodeLsbCheck
        $error("jtag_tap_ctrl: IDCODE_VALUE bit 0 must be 1");
    end

    localparam logic [IR_WIDTH-1:0] irSample  = opSample[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] irCapture = capIrPattern[IR_WIDTH-1:0];
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] irIdcode  = opIdcode[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] irReset   = irIdcode;
`else
    localparam logic [IR_WIDTH-1:0] irReset   = '1;
`endif

    tapStateE            state;
    logic [IR_WIDTH-1:0] irShift;
    logic [IR_WIDTH-1:0] irLatch;
    logic                bypassBit;
    logic                tdoQ;
    logic                tdoEnQ;
    instrE               instr;
    logic                bsrSel;
`ifdef JTAG_IDCODE_EN
    logic [31:0]         idShift;
`endif

    jtag_tap_fsm uFsm (
        .tck   (TCK),
        .trstN (TRST_N),
        .tms   (tap.TMS),
        .state (state)
    );

    always_comb begin
        instr = InstrBypass;
        if (irLatch == opExtest[IR_WIDTH-1:0]) begin
            instr = InstrExtest;
        end else if (irLatch == irSample) begin
            instr = InstrSample;
        end
`ifdef JTAG_IDCODE_EN
        else if (irLatch == irIdcode) begin
            instr = InstrIdcode;
        end
`endif
    end

    assign bsrSel = (instr == InstrExtest) || (instr == InstrSample);

    // Controls are gated by TRST_N so they read 0 for the whole reset window,
    // including before the first sampling edge.
    assign tap.ShiftDR   = TRST_N & bsrSel & (state == ShDR);
    assign tap.CaptureDR = TRST_N & bsrSel & (state == CapDR);
    assign tap.UpdateDR  = TRST_N & bsrSel & (state == UpdDR);
    assign tap.Mode      = TRST_N & (instr == InstrExtest);
    assign tap.ScanIn    = tap.TDI;
    assign tap.TDO       = tdoQ;
    assign tap.TDO_EN    = tdoEnQ;

    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            irShift   <= '0;
            bypassBit <= 1'b0;
        end else begin
            case (state)
                CapIR:   irShift   <= irCapture;
                ShIR:    irShift   <= {tap.TDI, irShift[IR_WIDTH-1:1]};
                CapDR:   bypassBit <= 1'b0;
                ShDR:    bypassBit <= tap.TDI;
                default: ;
            endcase
        end
    end

`ifdef JTAG_IDCODE_EN
    always_ff @(posedge TCK) begin
        if (!TRST_N || state == CapDR) begin
            idShift <= IDCODE_VALUE;
        end else if (state == ShDR && instr == InstrIdcode) begin
            idShift <= {tap.TDI, idShift[31:1]};
        end
    end
`endif

    always_ff @(negedge TCK) begin
        if (!TRST_N || state == TLR) begin
            irLatch <= irReset;
        end else if (state == UpdIR) begin
            irLatch <= irShift;
        end

        if (!TRST_N) begin
            tdoQ   <= 1'b0;
            tdoEnQ <= 1'b0;
        end else begin
            tdoEnQ <= (state == ShDR) || (state == ShIR);
            case (state)
                ShIR: tdoQ <= irShift[0];
                ShDR: begin
                    case (instr)
                        InstrExtest, InstrSample: tdoQ <= tap.ScanOut;
`ifdef JTAG_IDCODE_EN
                        InstrIdcode:              tdoQ <= idShift[0];
`endif
                        default:                  tdoQ <= bypassBit;
                    endcase
                end
                default: tdoQ <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl with a 16-cell boundary chain; expected scan streams
// come from a bit-queue model of "preloaded capture bits followed by TDI".
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IdValue = 32'h020F_30DD;
`ifdef JTAG_IDCODE_EN
    localparam bit idEn = 1'b1;
`else
    localparam bit idEn = 1'b0;
`endif
    localparam logic [3:0] resetCode = idEn ? 4'b0010 : 4'b1111;

    logic tck   = 1'b0;
    logic trstN = 1'b0;
    int   nCompared = 0;
    int   nMismatch = 0;

    jtag_tap_ctrl_if bus ();

    jtag_tap_ctrl #(
        .IR_WIDTH     (4),
        .IDCODE_VALUE (IdValue)
    ) dut (
        .TCK    (tck),
        .TRST_N (trstN),
        .tap    (bus)
    );

    always #5 tck = ~tck;

    // External 16-cell boundary chain with negedge update register.
    logic [15:0] pins;
    logic [15:0] cells;
    logic [15:0] updReg;
    int updCount = 0;
    int capCount = 0;
    int shiftCount = 0;

    assign bus.ScanOut = cells[0];

    always @(posedge tck) begin
        if (bus.CaptureDR === 1'b1) cells <= pins;
        else if (bus.ShiftDR === 1'b1) cells <= {bus.ScanIn, cells[15:1]};
    end

    always @(negedge tck) begin
        if (bus.UpdateDR === 1'b1) begin
            updReg   <= cells;
            updCount <= updCount + 1;
        end
        if (bus.CaptureDR === 1'b1) capCount <= capCount + 1;
        if (bus.ShiftDR === 1'b1) shiftCount <= shiftCount + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp)
        else begin
            nMismatch++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scan stream = capture contents (preN bits) followed by TDI bits, first n out.
    function automatic logic [63:0] expectScan(input int preN, input logic [63:0] pre,
                                               input int n, input logic [63:0] din);
        logic q[$];
        logic [63:0] r = '0;
        for (int i = 0; i < preN; i++) q.push_back(pre[i]);
        for (int i = 0; i < n; i++) q.push_back(din[i]);
        for (int i = 0; i < n; i++) r[i] = q.pop_front();
        return r;
    endfunction

    // 0 = boundary chain, 1 = bypass, 2 = ID register
    function automatic int kindOf(input logic [3:0] code);
        if (code == 4'd0 || code == 4'd1) return 0;
        if (idEn && code == 4'd2) return 2;
        return 1;
    endfunction

    // Starts and ends at a sample point (1 time unit after a negedge).
    task automatic tick(input logic tms, input logic tdi, output logic tdo);
        tdo = bus.TDO;
        bus.TMS = tms;
        bus.TDI = tdi;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic scan(input bit isIr, input int n, input logic [63:0] din,
                        output logic [63:0] dout);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b);
        if (isIr) tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            if (i == 0) check("tdoEnInShift", 64'(bus.TDO_EN), 64'd1);
            tick(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic loadIr(input logic [3:0] code);
        logic [63:0] dout;
        scan(1'b1, 4, {60'd0, code}, dout);
        check("irCapture", dout, expectScan(4, 64'h1, 4, {60'd0, code}));
        check("irFirstTwo", 64'(dout[1:0]), 64'h1);
        check("modeAfterIr", 64'(bus.Mode), 64'(code == 4'd0));
    endtask

    task automatic doDr(input logic [3:0] code, input int n, input logic [63:0] din,
                        input string tag);
        int k  = kindOf(code);
        int u0 = updCount;
        int c0 = capCount;
        int s0 = shiftCount;
        int preN;
        logic [63:0] pre;
        logic [63:0] dout;
        logic [63:0] exp;
        case (k)
            0:       begin preN = 16; pre = {48'd0, pins}; end
            2:       begin preN = 32; pre = {32'd0, IdValue}; end
            default: begin preN = 1;  pre = '0; end
        endcase
        exp = expectScan(preN, pre, n, din);
        scan(1'b0, n, din, dout);
        check({tag, ".tdo"}, dout, exp);
        check({tag, ".updPulses"}, 64'(updCount - u0), 64'(k == 0));
        check({tag, ".capPulses"}, 64'(capCount - c0), 64'(k == 0));
        check({tag, ".shiftCycles"}, 64'(shiftCount - s0), (k == 0) ? 64'(n) : 64'd0);
        if (k == 0) check({tag, ".chain"}, 64'(updReg), 64'(din[n-16 +: 16]));
        check({tag, ".mode"}, 64'(bus.Mode), 64'(code == 4'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        b;
        logic [3:0]  code;
        logic [63:0] din;
        int          k;
        int          n;
        int          u0;

        bus.TMS = 1'b1;
        bus.TDI = 1'b0;
        pins    = '0;

        repeat (3) @(negedge tck);
        #1;
        check("rstShiftDR",   64'(bus.ShiftDR),   64'd0);
        check("rstCaptureDR", 64'(bus.CaptureDR), 64'd0);
        check("rstUpdateDR",  64'(bus.UpdateDR),  64'd0);
        check("rstMode",      64'(bus.Mode),      64'd0);
        check("rstTdo",       64'(bus.TDO),       64'd0);
        check("rstTdoEn",     64'(bus.TDO_EN),    64'd0);

        trstN = 1'b1;
        repeat (5) tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        check("tlrMode", 64'(bus.Mode), 64'd0);
        check("rtiTdoEn", 64'(bus.TDO_EN), 64'd0);
        doDr(resetCode, 32, {$urandom, $urandom}, "resetInstrScan");

        pins = 16'($urandom);
        loadIr(4'b0000);
        doDr(4'b0000, 16, 64'hA5C3, "extestA5C3");
        for (int i = 0; i < 3; i++) begin
            pins = 16'($urandom);
            doDr(4'b0000, 16, {$urandom, $urandom}, "extestRand");
        end

        pins = 16'h1234;
        loadIr(4'b0001);
        doDr(4'b0001, 16, {$urandom, $urandom}, "sample1234");
        for (int i = 0; i < 2; i++) begin
            pins = 16'($urandom);
            doDr(4'b0001, 16, {$urandom, $urandom}, "sampleRand");
        end

        loadIr(4'b1011);
        doDr(4'b1011, 4, 64'b1101, "bypass1011");

        loadIr(4'b0010);
        doDr(4'b0010, 40, {$urandom, $urandom}, "idcodeOp");

        loadIr(4'b1111);
        doDr(4'b1111, 9, {$urandom, $urandom}, "bypassOnes");

        for (int i = 0; i < 6; i++) begin
            code = 4'($urandom_range(0, 15));
            k    = kindOf(code);
            n    = (k == 0) ? 16 : (k == 2) ? 40 : int'($urandom_range(2, 30));
            pins = 16'($urandom);
            loadIr(code);
            doDr(code, n, {$urandom, $urandom}, "randInstr");
        end

        loadIr(4'b0000);
        for (int i = 0; i < 40; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b);
        repeat (5) tick(1'b1, 1'b0, b);
        check("walkToTlrMode", 64'(bus.Mode), 64'd0);
        check("walkToTlrTdoEn", 64'(bus.TDO_EN), 64'd0);
        tick(1'b0, 1'b0, b);
        doDr(resetCode, 33, {$urandom, $urandom}, "afterWalk");

        pins = 16'($urandom);
        loadIr(4'b0000);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'($urandom_range(0, 1)), b);
        check("preAbortShiftDR", 64'(bus.ShiftDR), 64'd1);
        u0    = updCount;
        trstN = 1'b0;
        tick(1'b0, 1'b0, b);
        check("abortShiftDR", 64'(bus.ShiftDR), 64'd0);
        check("abortMode",    64'(bus.Mode),    64'd0);
        check("abortTdoEn",   64'(bus.TDO_EN),  64'd0);
        trstN = 1'b1;
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        check("abortNoUpdate", 64'(updCount - u0), 64'd0);
        din = {$urandom, $urandom};
        doDr(resetCode, 32, din, "afterAbort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register width, legal range 2..8.
REQ-002 Parameter IDCODE_VALUE, default 32'h020F_30DD: device ID; bit 0 SHALL be 1.
REQ-003 TCK  input  1: sole clock; state, shift and capture registers SHALL update on posedge; TDO and update registers SHALL update on negedge.
REQ-004 TRST_N  input  1: reset, synchronous and active-low, sampled on TCK.
REQ-005 TMS  input  1: TAP mode select, sampled on posedge TCK.
REQ-006 TDI  input  1: serial data in.
REQ-007 TDO  output  1: serial data out, registered on negedge TCK.
REQ-008 TDO_EN  output  1: high only in Shift-DR or Shift-IR, registered with TDO.
REQ-009 ScanIn  output  1: boundary chain serial input, equal to TDI.
REQ-010 ScanOut  input  1: boundary chain serial output, returned to the controller.
REQ-011 ShiftDR, CaptureDR, UpdateDR  output  1 each: boundary chain controls.
REQ-012 Mode  output  1: boundary cell output select; 1 drives the update register onto pins.

Function
REQ-013 FSM SHALL implement the 16 IEEE 1149.1 states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, and the IR equivalents SelIR through UpdIR.
REQ-014 Transitions on TMS=1/0: TLR->TLR/RTI; RTI->SelDR/RTI; SelDR->SelIR/CapDR; SelIR->TLR/CapIR; Cap->Ex1/Sh; Sh->Ex1/Sh; Ex1->Upd/Pause; Pause->Ex2/Pause; Ex2->Upd/Sh; Upd->SelDR/RTI; IR and DR branches are symmetric.
REQ-015 Five consecutive posedges with TMS=1 SHALL reach TLR from any state.
REQ-016 IR SHALL be a shift register plus a negedge-updated latch; CapIR loads shift = {0..0,01}; ShIR shifts TDI into the MSB and the LSB goes to TDO; the latch loads at negedge in UpdIR.
REQ-017 Decode: all-0 = EXTEST; 0..01 = SAMPLE; 0..010 = IDCODE; all-1 = BYPASS; every other code SHALL select BYPASS.
REQ-018 BSR is selected under EXTEST or SAMPLE; ShiftDR, CaptureDR and UpdateDR SHALL be Moore decodes of ShDR, CapDR and UpdDR, gated by BSR select, and 0 otherwise.
REQ-019 Mode SHALL be 1 only while the latched instruction is EXTEST.
REQ-020 Bypass register is 1 bit; it SHALL capture 0 in CapDR and shift TDI in ShDR.
REQ-021 TDO source: ShIR -> IR shift LSB; ShDR -> ScanOut (BSR), ID shift LSB (IDCODE) or bypass bit; other states hold TDO at 0.
REQ-022 A DR scan with BSR selected SHALL have latency of exactly N ShDR posedges for an N-cell chain; the controller adds no stage.
REQ-023 Entering TLR SHALL force the latched instruction to its reset value at the next negedge.

Reset
REQ-024 TRST_N=0 at posedge SHALL set state to TLR, clear IR shift and bypass, and load the ID shift register with IDCODE_VALUE.
REQ-025 While reset is asserted: outputs ShiftDR, CaptureDR, UpdateDR, Mode, TDO and TDO_EN SHALL be 0, and the IR latch SHALL hold its reset instruction (reset is sampled at the next negedge).
REQ-026 Reset during ShDR or ShIR SHALL abort the scan with no update pulse.

Configuration
REQ-027 Macro JTAG_IDCODE_EN is defined: 32-bit ID register present; it captures IDCODE_VALUE in CapDR; reset instruction is IDCODE.
REQ-028 Macro JTAG_IDCODE_EN is undefined: no ID register; code 0..010 decodes to BYPASS; reset instruction is BYPASS.

Structure
REQ-029 Package jtag_pkg SHALL hold the state enum (4-bit encoding), opcode constants and the CapIR pattern.
REQ-030 Sub-module jtag_tap_fsm SHALL contain the state register and next-state logic only; decode and registers stay in jtag_tap_ctrl.

Verification
REQ-031 Reset, then TMS=1 for 5 cycles -> state TLR; Mode=0; with IDCODE enabled, a DR scan of 32 bits returns 32'h020F_30DD LSB first.
REQ-032 Load IR=4'b0000 (EXTEST), then shift 16 bits of 16'hA5C3 through a 16-cell chain -> UpdateDR pulses once; Mode=1; chain output = 16'hA5C3.
REQ-033 Load IR=4'b0001 (SAMPLE) -> CaptureDR pulses once; captured pin value 16'h1234 appears on TDO LSB first; Mode=0.
REQ-034 Load IR=4'b1011 (undefined) -> BYPASS; TDI pattern 1,0,1,1 appears on TDO delayed by one bit; ShiftDR stays 0.
REQ-035 During IR shift, the first two bits on TDO are 1,0 (capture pattern).
REQ-036 Assert TRST_N=0 mid-ShDR -> next state TLR; no UpdateDR pulse; Mode=0.
